// File: rtl/uart_word_assembler.sv
// Purpose : packs UART bytes little-endian into 32-bit words and queues them in a FWFT FIFO.
// Latency : the 4th byte strobe at edge N makes the word visible on word_data right after edge N.
// Backpressure: none towards the receiver; a word completed while the FIFO is full is dropped (sticky overflow).
//
// Ports:
//   clk, rstn              clock and synchronous active-low reset
//   in_data/in_valid       received byte and its one-cycle strobe
//   in_ferr                framing-error level from the receiver (sticky in ferr_seen)
//   flush                  synchronous clear of assembly state, FIFO and flags
//   word_data/valid/ready  FIFO head towards the loader, valid/ready handshake
//   byte_cnt               bytes held in the partial word
//   level                  words stored in the FIFO
//   overflow, ferr_seen    sticky error flags
module uart_word_assembler #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_ferr,
  input  logic                     flush,
  output logic [31:0]              word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [1:0]               byte_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     ferr_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   sr_q, sr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          ferr_seen_q, ferr_seen_d;
  logic [31:0]   mem_q [DEPTH];

  logic          empty;
  logic          full;
  logic          pop;
  logic          word_done;
  logic          push;
  logic [31:0]   word_in;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // The 4th byte never lands in the shift register; it goes straight into the word.
  assign word_in   = {in_data, sr_q};
  assign word_done = in_valid && (byte_cnt_q == 2'd3) && !flush;
  assign pop       = !empty && word_ready && !flush;
  // A simultaneous pop frees the slot, so a full FIFO can still accept the word.
  assign push      = word_done && (!full || pop);

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    sr_d        = sr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    ferr_seen_d = ferr_seen_q || in_ferr;

    if (in_valid) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    sr_d[7:0]   = in_data;
        2'd1:    sr_d[15:8]  = in_data;
        2'd2:    sr_d[23:16] = in_data;
        default: sr_d        = sr_q;
      endcase
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (word_done && !push) overflow_d = 1'b1;

    // flush clears everything and overrides any byte, pop or error this cycle
    if (flush) begin
      byte_cnt_d  = 2'd0;
      sr_d        = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      ferr_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt_q  <= 2'd0;
      sr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      ferr_seen_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      sr_q        <= sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      ferr_seen_q <= ferr_seen_d;
    end
  end

  // Storage is deliberately left uninitialised; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (rstn && push) mem_q[wr_ptr_q[AW-1:0]] <= word_in;
  end

  // Gating the head with empty keeps word_data at zero after reset/flush.
  assign word_data  = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
  assign word_valid = !empty;
  assign byte_cnt   = byte_cnt_q;
  assign level      = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign ferr_seen  = ferr_seen_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Purpose : directed, self-checking bench for uart_word_assembler at DEPTH=16.
// Latency : outputs sampled 1ns after each rising edge; inputs changed at the same point.
// Backpressure: word_ready driven explicitly by each sequence.
module tb_uart_word_assembler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ferr;
  logic        flush;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  byte_cnt;
  logic [4:0]  level;
  logic        overflow;
  logic        ferr_seen;

  int total = 0;
  int bad   = 0;

  uart_word_assembler #(.DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ferr(in_ferr), .flush(flush), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .byte_cnt(byte_cnt),
    .level(level), .overflow(overflow), .ferr_seen(ferr_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] bytes;   // bytes[0] is sent first
    logic [31:0]     exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pop_one();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    vecs[0].bytes = {8'h12, 8'h34, 8'h56, 8'h78}; vecs[0].exp = 32'h12345678;
    vecs[1].bytes = {8'h00, 8'h00, 8'h00, 8'h00}; vecs[1].exp = 32'h00000000;
    vecs[2].bytes = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[2].exp = 32'hFFFFFFFF;
    vecs[3].bytes = {8'h04, 8'h03, 8'h02, 8'h01}; vecs[3].exp = 32'h04030201;

    rstn = 1'b0; in_data = '0; in_valid = 1'b0; in_ferr = 1'b0;
    flush = 1'b0; word_ready = 1'b0;
    tick(); tick();
    rstn = 1'b1;

    // reset state
    chk("rst_byte_cnt",   32'(byte_cnt),   32'd0);
    chk("rst_level",      32'(level),      32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data",  word_data,       32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_ferr_seen",  32'(ferr_seen),  32'd0);

    // table: assemble one word, check FWFT timing, then pop it
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 3; i++) send_byte(vecs[v].bytes[i]);
      chk($sformatf("vec%0d_cnt3", v),       32'(byte_cnt),   32'd3);
      chk($sformatf("vec%0d_not_valid", v),  32'(word_valid), 32'd0);
      send_byte(vecs[v].bytes[3]);
      chk($sformatf("vec%0d_valid", v),      32'(word_valid), 32'd1);
      chk($sformatf("vec%0d_data", v),       word_data,       vecs[v].exp);
      chk($sformatf("vec%0d_level", v),      32'(level),      32'd1);
      chk($sformatf("vec%0d_cnt0", v),       32'(byte_cnt),   32'd0);
      pop_one();
      chk($sformatf("vec%0d_popped", v),     32'(word_valid), 32'd0);
    end

    // ready while empty is ignored
    pop_one();
    chk("empty_pop_level", 32'(level), 32'd0);

    // partial word then flush; flush also wins over a simultaneous byte
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD);
    chk("pre_flush_cnt", 32'(byte_cnt), 32'd3);
    flush = 1'b1; in_data = 8'h55; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_cnt",   32'(byte_cnt), 32'd0);
    chk("flush_level", 32'(level),    32'd0);
    send_word(32'hDEADBEEF);
    chk("deadbeef_data",  word_data,   32'hDEADBEEF);
    chk("deadbeef_level", 32'(level),  32'd1);
    do_flush();

    // overflow: 17 words with no drain
    for (int k = 1; k <= 17; k++) send_word(32'hA0000000 + k);
    chk("ovf_level",    32'(level),    32'd16);
    chk("ovf_flag",     32'(overflow), 32'd1);
    chk("ovf_head",     word_data,     32'hA0000001);
    chk("ovf_byte_cnt", 32'(byte_cnt), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain%0d", k), word_data, 32'hA0000000 + k);
      pop_one();
    end
    chk("drain_empty",   32'(word_valid), 32'd0);
    chk("ovf_is_sticky", 32'(overflow),   32'd1);
    do_flush();
    chk("flush_clears_ovf", 32'(overflow), 32'd0);

    // full FIFO with a pop on the completing edge: no overflow
    for (int k = 1; k <= 16; k++) send_word(32'hB0000000 + k);
    chk("full_level", 32'(level), 32'd16);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    word_ready = 1'b1;
    send_byte(8'h44);
    word_ready = 1'b0;
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_level",    32'(level),    32'd16);
    chk("pp_head",     word_data,     32'hB0000002);
    for (int k = 0; k < 15; k++) pop_one();
    chk("pp_tail", word_data, 32'h44332211);
    do_flush();

    // framing error mid-word
    send_byte(8'h01); send_byte(8'h02);
    in_ferr = 1'b1; tick(); in_ferr = 1'b0;
    chk("ferr_set", 32'(ferr_seen), 32'd1);
    tick(); tick();
    chk("ferr_sticky", 32'(ferr_seen), 32'd1);
    send_byte(8'h03); send_byte(8'h04);
    chk("ferr_word", word_data, 32'h04030201);
    do_reset();
    chk("ferr_rst", 32'(ferr_seen), 32'd0);

    // reset after 3 stored words and 2 bytes
    for (int k = 1; k <= 3; k++) send_word(32'hC0000000 + k);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("pre_rst_level", 32'(level),    32'd3);
    chk("pre_rst_cnt",   32'(byte_cnt), 32'd2);
    do_reset();
    chk("rst2_cnt",   32'(byte_cnt),   32'd0);
    chk("rst2_level", 32'(level),      32'd0);
    chk("rst2_valid", 32'(word_valid), 32'd0);
    chk("rst2_data",  word_data,       32'd0);
    send_word(32'hCAFEF00D);
    chk("rst2_fresh_word",  word_data,  32'hCAFEF00D);
    chk("rst2_fresh_level", 32'(level), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
